xor_reduce_pipe: RTL and testbench

XOR_REDUCE_PIPE -- requirements
Module: xor_reduce_pipe

---
 rtl/xor_pkg.sv | 41 ++++
 rtl/xor_reduce_stage.sv | 61 ++++++
 rtl/xor_reduce_pipe.sv | 136 +++++++++++++
 tb/tb_xor_reduce_pipe.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xor_pkg.sv
`timescale 1ns / 1ps
// xor_pkg: tree sizing helpers and accumulator state encoding
// shared by the XOR reduction pipeline.
package xor_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OPEN = 1'b1
  } acc_st_e;

  // Node count feeding tree level k (level 0 is the raw word).
  function automatic int nodes_at(int width, int leaf, int k);
    int n;
    n = width;
    for (int i = 0; i < k; i++) n = (n + leaf - 1) / leaf;
    return n;
  endfunction

  function automatic int calc_stages(int width, int leaf);
    int n;
    int s;
    n = width;
    s = 0;
    for (int i = 0; i < 64; i++) begin
      if (n > 1) begin
        n = (n + leaf - 1) / leaf;
        s++;
      end
    end
    return (s < 1) ? 1 : s;
  endfunction

  // Bit offset of level k inside the flattened level vector.
  function automatic int off_at(int width, int leaf, int k);
    int s;
    s = 0;
    for (int i = 0; i < k; i++) s += nodes_at(width, leaf, i);
    return s;
  endfunction

endpackage

// File: rtl/xor_reduce_stage.sv
`timescale 1ns / 1ps
// xor_reduce_stage: one registered level of the XOR tree,
// LEAF inputs per node, partial last node zero-padded.
module xor_reduce_stage #(
  parameter int IN_W = 8,
  parameter int LEAF = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_en,
  input  logic [IN_W-1:0]               i_d,
  input  logic                          i_vi,
  input  logic                          i_fs,
  input  logic                          i_fe,
  output logic [(IN_W+LEAF-1)/LEAF-1:0] o_q,
  output logic                          o_vo,
  output logic                          o_fs,
  output logic                          o_fe
);
  localparam int OUT_W = (IN_W + LEAF - 1) / LEAF;
  localparam int PAD_W = OUT_W * LEAF;

  logic [PAD_W-1:0] w_pad;
  logic [OUT_W-1:0] w_red;
  logic [OUT_W-1:0] r_q;
  logic             r_vo;
  logic             r_fs;
  logic             r_fe;

  always_comb begin
    w_pad = '0;
    w_pad[IN_W-1:0] = i_d;
  end

  always_comb begin
    w_red = '0;
    for (int n = 0; n < OUT_W; n++) begin
      w_red[n] = ^w_pad[n*LEAF +: LEAF];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q  <= '0;
      r_vo <= 1'b0;
      r_fs <= 1'b0;
      r_fe <= 1'b0;
    end else if (i_en) begin
      r_q  <= w_red;
      r_vo <= i_vi;
      r_fs <= i_fs;
      r_fe <= i_fe;
    end
  end

  assign o_q  = r_q;
  assign o_vo = r_vo;
  assign o_fs = r_fs;
  assign o_fe = r_fe;

endmodule

// File: rtl/xor_reduce_pipe.sv
`timescale 1ns / 1ps
// xor_reduce_pipe: pipelined LEAF-ary XOR reduction of each word,
// with an optional frame-parity accumulator on the reduced stream.
module xor_reduce_pipe
  import xor_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEAF  = 4,
  parameter int ACCUM = 1
) (
  input  logic             CK,
  input  logic             CD,
  input  logic             SP,
  input  logic [WIDTH-1:0] D,
  input  logic             VI,
  input  logic             FS,
  input  logic             FE,
  output logic             Z,
  output logic             VO,
  output logic             PZ,
  output logic             PV
);
  localparam int STAGES = calc_stages(WIDTH, LEAF);
  localparam int TOT_W  = off_at(WIDTH, LEAF, STAGES + 1);

  // All tree levels packed end to end; the last level is one bit.
  logic [TOT_W-1:0] w_all;
  logic [STAGES:0]  w_v;
  logic [STAGES:0]  w_fs;
  logic [STAGES:0]  w_fe;

  assign w_all[WIDTH-1:0] = D;
  assign w_v[0]  = VI;
  assign w_fs[0] = VI & FS;
  assign w_fe[0] = VI & FE;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int IW = nodes_at(WIDTH, LEAF, k);
    localparam int OW = nodes_at(WIDTH, LEAF, k + 1);
    localparam int IO = off_at(WIDTH, LEAF, k);
    localparam int OO = off_at(WIDTH, LEAF, k + 1);

    xor_reduce_stage #(
      .IN_W(IW),
      .LEAF(LEAF)
    ) u_stage (
      .i_clk(CK),
      .i_rst(CD),
      .i_en (SP),
      .i_d  (w_all[IO +: IW]),
      .i_vi (w_v[k]),
      .i_fs (w_fs[k]),
      .i_fe (w_fe[k]),
      .o_q  (w_all[OO +: OW]),
      .o_vo (w_v[k+1]),
      .o_fs (w_fs[k+1]),
      .o_fe (w_fe[k+1])
    );
  end

  assign Z  = w_all[TOT_W-1];
  assign VO = w_v[STAGES];

  if (ACCUM != 0) begin : g_acc
    acc_st_e r_st;
    acc_st_e w_st_n;
    logic    r_acc;
    logic    w_acc_n;
    logic    r_pz;
    logic    w_pz_n;
    logic    r_pv;
    logic    w_pv_n;
    logic    w_dfs;
    logic    w_dfe;
    logic    w_open;

    assign w_dfs  = w_fs[STAGES];
    assign w_dfe  = w_fe[STAGES];
    assign w_open = (r_st == ST_OPEN);

    always_ff @(posedge CK or posedge CD) begin
      if (CD) begin
        r_st  <= ST_IDLE;
        r_acc <= 1'b0;
        r_pz  <= 1'b0;
        r_pv  <= 1'b0;
      end else if (SP) begin
        r_st  <= w_st_n;
        r_acc <= w_acc_n;
        r_pz  <= w_pz_n;
        r_pv  <= w_pv_n;
      end
    end

    // A start always restarts; beats outside a frame are dropped.
    always_comb begin
      w_st_n  = r_st;
      w_acc_n = r_acc;
      w_pz_n  = r_pz;
      w_pv_n  = 1'b0;
      if (VO) begin
        unique case (1'b1)
          (w_dfs && w_dfe): begin
            w_acc_n = Z;
            w_pz_n  = Z;
            w_pv_n  = 1'b1;
            w_st_n  = ST_IDLE;
          end
          (w_dfs && !w_dfe): begin
            w_acc_n = Z;
            w_st_n  = ST_OPEN;
          end
          (!w_dfs && w_open && w_dfe): begin
            w_acc_n = r_acc ^ Z;
            w_pz_n  = r_acc ^ Z;
            w_pv_n  = 1'b1;
            w_st_n  = ST_IDLE;
          end
          (!w_dfs && w_open && !w_dfe): begin
            w_acc_n = r_acc ^ Z;
          end
          default: ;
        endcase
      end
    end

    assign PZ = r_pz;
    assign PV = r_pv;
  end else begin : g_noacc
    logic w_unused;
    assign w_unused = w_fs[STAGES] ^ w_fe[STAGES];
    assign PZ = 1'b0;
    assign PV = 1'b0;
  end

endmodule

// File: tb/tb_xor_reduce_pipe.sv
`timescale 1ns / 1ps
// tb_xor_reduce_pipe: three tree shapes driven by one stimulus,
// checked every cycle against a history-based frame model.
module tb_xor_reduce_pipe;

  logic        ck = 1'b0;
  logic        cd;
  logic        sp;
  logic        vi;
  logic        fs;
  logic        fe;
  logic [63:0] d;
  logic [2:0]  z;
  logic [2:0]  vo;
  logic [2:0]  pz;
  logic [2:0]  pv;

  int n_chk  = 0;
  int n_fail = 0;
  int cnt;

  always #5 ck = ~ck;

  // index 0: WIDTH=8 LEAF=4 (2 stages), 1: WIDTH=1 (1), 2: WIDTH=64 LEAF=2 (6)
  xor_reduce_pipe #(.WIDTH(8), .LEAF(4), .ACCUM(1)) u_w8 (
    .CK(ck), .CD(cd), .SP(sp), .D(d[7:0]), .VI(vi), .FS(fs), .FE(fe),
    .Z(z[0]), .VO(vo[0]), .PZ(pz[0]), .PV(pv[0])
  );
  xor_reduce_pipe #(.WIDTH(1), .LEAF(2), .ACCUM(1)) u_w1 (
    .CK(ck), .CD(cd), .SP(sp), .D(d[0:0]), .VI(vi), .FS(fs), .FE(fe),
    .Z(z[1]), .VO(vo[1]), .PZ(pz[1]), .PV(pv[1])
  );
  xor_reduce_pipe #(.WIDTH(64), .LEAF(2), .ACCUM(1)) u_w64 (
    .CK(ck), .CD(cd), .SP(sp), .D(d), .VI(vi), .FS(fs), .FE(fe),
    .Z(z[2]), .VO(vo[2]), .PZ(pz[2]), .PV(pv[2])
  );

  typedef struct packed {
    bit       vi;
    bit       fs;
    bit       fe;
    bit [2:0] p;
    bit       ends;
    bit [2:0] fp;
  } beat_t;

  // One entry per enabled clock edge since the last reset.
  beat_t hist[$];

  function automatic int lat(int k);
    return (k == 0) ? 2 : (k == 1) ? 1 : 6;
  endfunction

  task automatic check(string nm, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // A frame ends at beat i if i has FE and, scanning back, an FS is
  // reached before any earlier FE; its parity covers FS..FE inclusive.
  always @(posedge ck or posedge cd) begin : rec
    beat_t    b;
    bit [2:0] acc;
    if (cd) begin
      hist.delete();
    end else if (sp) begin
      b    = '0;
      b.vi = vi;
      b.fs = vi & fs;
      b.fe = vi & fe;
      b.p  = {^d, d[0], ^d[7:0]};
      if (b.fe) begin
        acc = b.p;
        if (b.fs) b.ends = 1'b1;
        else begin
          for (int j = hist.size() - 1; j >= 0; j--) begin
            if (hist[j].fe) break;
            if (hist[j].vi) acc ^= hist[j].p;
            if (hist[j].fs) begin
              b.ends = 1'b1;
              break;
            end
          end
        end
        b.fp = acc;
      end
      hist.push_back(b);
    end
  end

  task automatic cmp(int k);
    int n;
    int bi;
    int ci;
    bit evo;
    bit ez;
    bit epv;
    bit epz;
    string tg;
    n   = hist.size();
    bi  = n - lat(k);
    ci  = bi - 1;
    evo = 1'b0;
    ez  = 1'b0;
    epv = 1'b0;
    epz = 1'b0;
    tg  = $sformatf("m%0d", k);
    if (bi >= 0) begin
      evo = hist[bi].vi;
      ez  = hist[bi].p[k];
    end
    if (ci >= 0) epv = hist[ci].ends;
    for (int j = ci; j >= 0; j--) begin
      if (hist[j].ends) begin
        epz = hist[j].fp[k];
        break;
      end
    end
    check({tg, ".vo"}, vo[k], evo);
    if (evo || bi < 0) check({tg, ".z"}, z[k], ez);
    check({tg, ".pv"}, pv[k], epv);
    check({tg, ".pz"}, pz[k], epz);
  endtask

  always @(negedge ck) begin
    for (int k = 0; k < 3; k++) cmp(k);
  end

  task automatic step(bit s, bit v, bit f_s, bit f_e, logic [63:0] dd);
    @(posedge ck);
    #1;
    sp = s;
    vi = v;
    fs = f_s;
    fe = f_e;
    d  = dd;
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
  endtask

  initial begin
    cd = 1'b1;
    sp = 1'b1;
    vi = 1'b0;
    fs = 1'b0;
    fe = 1'b0;
    d  = '0;
    repeat (3) @(posedge ck);
    #1;
    check("rst.z", z, 3'b000);
    check("rst.vo", vo, 3'b000);
    check("rst.pz", pz, 3'b000);
    check("rst.pv", pv, 3'b000);
    #2 cd = 1'b0;

    // single-word latency on all three shapes
    step(1, 1, 0, 0, 64'h0000_0001_0000_00A5);
    step(1, 1, 0, 0, 64'h8000_0000_0000_0007);
    check("lat1.z", z[1], 1'b1);
    check("lat1.vo", vo[1], 1'b1);
    idle();
    check("a5.z", z[0], 1'b0);
    check("a5.vo", vo[0], 1'b1);
    check("lat1.z2", z[1], 1'b1);
    idle();
    check("07.z", z[0], 1'b1);
    check("07.vo", vo[0], 1'b1);
    check("lat1.vo0", vo[1], 1'b0);
    idle();
    idle();
    idle();
    check("lat6.z", z[2], 1'b1);
    check("lat6.vo", vo[2], 1'b1);
    idle();
    check("lat6.z2", z[2], 1'b0);
    idle();
    check("lat6.vo0", vo[2], 1'b0);

    // one-word frame
    step(1, 1, 1, 1, 64'h80);
    idle();
    idle();
    check("one.z", z[0], 1'b1);
    idle();
    check("one.pv", pv[0], 1'b1);
    check("one.pz", pz[0], 1'b1);
    idle();
    check("one.pv0", pv[0], 1'b0);
    check("one.hold", pz[0], 1'b1);

    // three-word frame
    step(1, 1, 1, 0, 64'h01);
    step(1, 1, 0, 0, 64'h03);
    step(1, 1, 0, 1, 64'h07);
    check("s3.z0", z[0], 1'b1);
    idle();
    check("s3.z1", z[0], 1'b0);
    idle();
    check("s3.z2", z[0], 1'b1);
    idle();
    check("s3.pv", pv[0], 1'b1);
    check("s3.pz", pz[0], 1'b0);
    idle();
    check("s3.pv0", pv[0], 1'b0);

    // restart while open: only the second frame reports
    cnt = 0;
    step(1, 1, 1, 0, 64'h01);
    if (pv[0]) cnt++;
    step(1, 1, 0, 0, 64'h03);
    if (pv[0]) cnt++;
    step(1, 1, 1, 0, 64'h07);
    if (pv[0]) cnt++;
    step(1, 1, 0, 1, 64'h00);
    if (pv[0]) cnt++;
    repeat (5) begin
      idle();
      if (pv[0]) cnt++;
    end
    check("rs.cnt", cnt, 1);
    check("rs.pz", pz[0], 1'b1);

    // clock-enable freeze for three cycles
    step(1, 1, 0, 0, 64'h01);
    step(1, 1, 0, 0, 64'h03);
    step(0, 1, 0, 0, 64'h07);
    check("sp.z0", z[0], 1'b1);
    step(0, 1, 0, 0, 64'h07);
    check("sp.z1", z[0], 1'b1);
    step(0, 1, 0, 0, 64'h07);
    check("sp.z2", z[0], 1'b1);
    check("sp.vo2", vo[0], 1'b1);
    step(1, 1, 0, 0, 64'h07);
    check("sp.z3", z[0], 1'b1);
    idle();
    check("sp.z4", z[0], 1'b0);
    check("sp.vo4", vo[0], 1'b1);
    idle();
    check("sp.z5", z[0], 1'b1);
    idle();
    check("sp.vo6", vo[0], 1'b0);

    // asynchronous reset mid-frame
    step(1, 1, 1, 0, 64'h01);
    step(1, 1, 0, 0, 64'h03);
    step(1, 1, 0, 0, 64'h07);
    #1 cd = 1'b1;
    #1;
    check("ar.z", z, 3'b000);
    check("ar.vo", vo, 3'b000);
    check("ar.pz", pz[0], 1'b0);
    check("ar.pv", pv[0], 1'b0);
    step(1, 1, 0, 1, 64'h07);
    step(1, 1, 0, 1, 64'h07);
    #2 cd = 1'b0;
    cnt = 0;
    step(1, 1, 0, 1, 64'h01);
    repeat (5) begin
      idle();
      if (pv[0]) cnt++;
    end
    check("ar.nopv", cnt, 0);
    step(1, 1, 1, 0, 64'h03);
    step(1, 1, 0, 1, 64'h01);
    cnt = 0;
    repeat (5) begin
      idle();
      if (pv[0]) cnt++;
    end
    check("ar.pv1", cnt, 1);
    check("ar.pz1", pz[0], 1'b1);

    // random stream, all shapes checked by the model every cycle
    for (int i = 0; i < 1200; i++) begin
      step($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 80,
           $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 12,
           {$urandom, $urandom});
    end
    repeat (10) idle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
